// File: rtl/aes_csr_pkg.sv
// Shared constants, FSM state types and helpers for the AES ECB AXI4-Lite CSR block.
package aes_csr_pkg;

  localparam int CTRL     = 'h00;
  localparam int STATUS   = 'h04;
  localparam int IRQ_EN   = 'h08;
  localparam int KEY_BASE = 'h10;

  localparam int START = 0;
  localparam int MODE  = 1;
  localparam int BUSY  = 0;
  localparam int DONE  = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic int din_base(input int key_words);
    return KEY_BASE + 4 * key_words;
  endfunction

  // Merge new_val into old_val one byte lane at a time under the write strobe.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/aes_axil_slv_if.sv
// AXI4-Lite slave handshake: independent write and read FSMs producing one-cycle
// register-access strobes for the CSR bank.
module aes_axil_slv_if
  import aes_csr_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                srst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  output logic                wr_en,
  output logic [ADDR_W-3:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  output logic                rd_en,
  output logic [ADDR_W-3:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data
);

  wr_state_e          w_state_reg;
  rd_state_e          r_state_reg;
  logic               bvalid_reg;
  logic               rvalid_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic               unused_addr_bits;

  // Ready is combinational so a handshake costs no extra cycle; AW and W only go together.
  assign wr_en   = !srst && (w_state_reg == W_IDLE) && awvalid && wvalid;
  assign awready = wr_en;
  assign wready  = wr_en;
  assign wr_addr = awaddr[ADDR_W-1:2];
  assign wr_data = wdata;
  assign wr_strb = wstrb;
  assign bresp   = RESP_OKAY;
  assign bvalid  = bvalid_reg;

  assign rd_en   = !srst && (r_state_reg == R_IDLE) && arvalid;
  assign arready = rd_en;
  assign rd_addr = araddr[ADDR_W-1:2];
  assign rresp   = RESP_OKAY;
  assign rvalid  = rvalid_reg;
  assign rdata   = rdata_reg;

  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  always_ff @(posedge clk) begin
    if (srst) begin
      w_state_reg <= W_IDLE;
      bvalid_reg  <= 1'b0;
    end else begin
      case (w_state_reg)
        W_IDLE: if (wr_en) begin
          w_state_reg <= W_RESP;
          bvalid_reg  <= 1'b1;
        end
        W_RESP: if (bready) begin
          w_state_reg <= W_IDLE;
          bvalid_reg  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state_reg <= R_IDLE;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: if (rd_en) begin
          r_state_reg <= R_DATA;
          rvalid_reg  <= 1'b1;
          rdata_reg   <= rd_data;
        end
        R_DATA: if (rready) begin
          r_state_reg <= R_IDLE;
          rvalid_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/aes_ecb_axil_csr.sv
// AES ECB control/status register bank: key, input block, mode, start pulse,
// captured output block and maskable done interrupt behind an AXI4-Lite slave.
module aes_ecb_axil_csr
  import aes_csr_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int KEY_WORDS          = 4,
  parameter int BLK_WORDS          = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic                            core_mode,
  output logic [32*KEY_WORDS-1:0]         core_key,
  output logic [32*BLK_WORDS-1:0]         core_din,
  input  logic                            core_busy,
  input  logic                            core_done,
  input  logic [32*BLK_WORDS-1:0]         core_dout,
  output logic                            irq
);

  localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int KEY_IDX  = KEY_BASE / 4;
  localparam int DIN_IDX  = din_base(KEY_WORDS) / 4;
  localparam int DOUT_IDX = DIN_IDX + BLK_WORDS;
  localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(CTRL / 4);
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(STATUS / 4);
  localparam logic [IDX_W-1:0] IRQEN_IDX  = IDX_W'(IRQ_EN / 4);

  logic                            wr_en, rd_en;
  logic [IDX_W-1:0]                wr_addr, rd_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data, rd_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;

  logic        start_reg, mode_reg, done_reg, irq_en_reg;
  logic [31:0] key_reg  [KEY_WORDS];
  logic [31:0] din_reg  [BLK_WORDS];
  logic [31:0] dout_reg [BLK_WORDS];
  logic        unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  aes_axil_slv_if #(
    .ADDR_W(C_S_AXI_ADDR_WIDTH),
    .DATA_W(C_S_AXI_DATA_WIDTH)
  ) u_slv_if (
    .clk(S_AXI_ACLK),         .srst(S_AXI_ARESET),
    .awaddr(S_AXI_AWADDR),    .awvalid(S_AXI_AWVALID), .awready(S_AXI_AWREADY),
    .wdata(S_AXI_WDATA),      .wstrb(S_AXI_WSTRB),     .wvalid(S_AXI_WVALID),
    .wready(S_AXI_WREADY),    .bresp(S_AXI_BRESP),     .bvalid(S_AXI_BVALID),
    .bready(S_AXI_BREADY),    .araddr(S_AXI_ARADDR),   .arvalid(S_AXI_ARVALID),
    .arready(S_AXI_ARREADY),  .rdata(S_AXI_RDATA),     .rresp(S_AXI_RRESP),
    .rvalid(S_AXI_RVALID),    .rready(S_AXI_RREADY),
    .wr_en(wr_en),            .wr_addr(wr_addr),       .wr_data(wr_data),
    .wr_strb(wr_strb),        .rd_en(rd_en),           .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      start_reg  <= 1'b0;
      mode_reg   <= 1'b0;
      done_reg   <= 1'b0;
      irq_en_reg <= 1'b0;
      for (int k = 0; k < KEY_WORDS; k++) key_reg[k] <= '0;
      for (int j = 0; j < BLK_WORDS; j++) begin
        din_reg[j]  <= '0;
        dout_reg[j] <= '0;
      end
    end else begin
      // START is dropped, not queued, when the core is already running.
      start_reg <= wr_en && (wr_addr == CTRL_IDX) && wr_strb[0] && wr_data[START] && !core_busy;
      if (wr_en && (wr_addr == CTRL_IDX) && wr_strb[0])
        mode_reg <= wr_data[MODE];
      if (wr_en && (wr_addr == IRQEN_IDX) && wr_strb[0])
        irq_en_reg <= wr_data[0];
      if (core_done)
        done_reg <= 1'b1;
      else if (wr_en && (wr_addr == STATUS_IDX) && wr_strb[0] && wr_data[DONE])
        done_reg <= 1'b0;
      for (int k = 0; k < KEY_WORDS; k++)
        if (wr_en && (wr_addr == IDX_W'(KEY_IDX + k)))
          key_reg[k] <= apply_strb(key_reg[k], wr_data, wr_strb);
      for (int j = 0; j < BLK_WORDS; j++) begin
        if (wr_en && (wr_addr == IDX_W'(DIN_IDX + j)))
          din_reg[j] <= apply_strb(din_reg[j], wr_data, wr_strb);
        if (core_done)
          dout_reg[j] <= core_dout[32*j +: 32];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr == CTRL_IDX)   rd_data[MODE] = mode_reg;
    if (rd_addr == STATUS_IDX) begin
      rd_data[BUSY] = core_busy;
      rd_data[DONE] = done_reg;
    end
    if (rd_addr == IRQEN_IDX)  rd_data[0] = irq_en_reg;
    for (int k = 0; k < KEY_WORDS; k++)
      if (rd_addr == IDX_W'(KEY_IDX + k)) rd_data = key_reg[k];
    for (int j = 0; j < BLK_WORDS; j++) begin
      if (rd_addr == IDX_W'(DIN_IDX + j))  rd_data = din_reg[j];
      if (rd_addr == IDX_W'(DOUT_IDX + j)) rd_data = dout_reg[j];
    end
  end

  for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_key_out
    assign core_key[32*gi +: 32] = key_reg[gi];
  end
  for (genvar gi = 0; gi < BLK_WORDS; gi++) begin : g_din_out
    assign core_din[32*gi +: 32] = din_reg[gi];
  end

  assign core_start = start_reg;
  assign core_mode  = mode_reg;
  assign irq        = done_reg & irq_en_reg;

endmodule

// File: tb/tb_aes_ecb_axil_csr.sv
// Directed bench for aes_ecb_axil_csr with KEY_WORDS = 8 (DIN at 0x30, DOUT at 0x40).
module tb_aes_ecb_axil_csr;

  localparam int KW = 8;

  logic         clk = 1'b0;
  logic         srst;
  logic [6:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         core_start, core_mode, core_busy, core_done, irq;
  logic [32*KW-1:0] core_key;
  logic [127:0] core_din, core_dout;

  int   vectors = 0;
  int   miscompares = 0;
  int   start_cnt = 0;
  logic start_mode = 1'b0;

  typedef struct {
    logic [6:0]  addr;
    logic        do_wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  aes_ecb_axil_csr #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7), .KEY_WORDS(KW), .BLK_WORDS(4)
  ) dut (
    .S_AXI_ACLK(clk),       .S_AXI_ARESET(srst),
    .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot),   .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),.S_AXI_WDATA(wdata),     .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),  .S_AXI_WREADY(wready),   .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),  .S_AXI_BREADY(bready),   .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot),  .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),     .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .core_start(core_start), .core_mode(core_mode), .core_key(core_key),
    .core_din(core_din),     .core_busy(core_busy), .core_done(core_done),
    .core_dout(core_dout),   .irq(irq)
  );

  // Counts cycles with core_start high, so one write must add exactly one.
  always @(negedge clk) begin
    if (core_start) begin
      start_cnt  <= start_cnt + 1;
      start_mode <= core_mode;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end else
      $display("ok   %s: 0x%08h", nm, act);
  endtask

  task automatic timeout_fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout, got no handshake, want one within 20 cycles", nm);
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0; #1;
    while (!(awready && wready) && n < 20) begin @(negedge clk); #1; n++; end
    if (!(awready && wready)) timeout_fail("aw_w_ready");
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0; #1;
    while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
    if (!bvalid) timeout_fail("bvalid");
    chk("bresp", 32'(bresp), 32'h0);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [6:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    n = 0; #1;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    if (!arready) timeout_fail("arready");
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    n = 0; #1;
    while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
    if (!rvalid) timeout_fail("rvalid");
    d = rdata;
    chk("rresp", 32'(rresp), 32'h0);
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  function automatic void add(input logic [6:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] e);
    vec_t v;
    v.addr = a; v.do_wr = w; v.wdata = d; v.strb = s; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] rd;
    int sc0;

    srst = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0; core_busy = 0; core_done = 0; core_dout = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_bvalid",  32'(bvalid),  0);
    chk("rst_rvalid",  32'(rvalid),  0);
    chk("rst_rdata",   rdata,        0);
    chk("rst_irq",     32'(irq),     0);
    chk("rst_start",   32'(core_start), 0);
    @(negedge clk); srst = 1'b0;

    add(7'h00, 0, 0, 4'h0, 0);
    add(7'h04, 0, 0, 4'h0, 0);
    add(7'h08, 0, 0, 4'h0, 0);
    add(7'h0C, 0, 0, 4'h0, 0);
    add(7'h10, 1, 32'hFFFFFFFF, 4'b0101, 32'h00FF00FF);
    for (int k = 0; k < KW; k++) add(7'(16 + 4*k), 1, {8{4'(k + 1)}}, 4'hF, {8{4'(k + 1)}});
    for (int j = 0; j < 4; j++)  add(7'(48 + 4*j), 1, 32'hA0 + 32'(j), 4'hF, 32'hA0 + 32'(j));
    add(7'h0C, 1, 32'hDEADBEEF, 4'hF, 0);
    add(7'h60, 1, 32'hDEADBEEF, 4'hF, 0);
    add(7'h40, 1, 32'hDEADBEEF, 4'hF, 0);
    add(7'h08, 1, 32'hFFFFFFFF, 4'hF, 1);
    add(7'h08, 1, 32'h00000000, 4'b1110, 1);
    add(7'h04, 1, 32'h00000003, 4'hF, 0);
    add(7'h00, 1, 32'hFFFFFFFF, 4'b0000, 0);

    foreach (tbl[i]) begin
      if (tbl[i].do_wr) axi_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
      axi_read(tbl[i].addr, rd);
      chk($sformatf("vec%0d@%02h", i, tbl[i].addr), rd, tbl[i].exp);
    end

    chk("no_start_strb0", 32'(start_cnt), 0);
    chk("core_key_w0", core_key[31:0], 32'h11111111);
    chk("core_key_w7", core_key[255:224], 32'h88888888);
    chk("core_din_w3", core_din[127:96], 32'hA3);

    // START with mode=1 while idle, then again while busy.
    sc0 = start_cnt;
    axi_write(7'h00, 32'h3, 4'hF);
    chk("start_pulses", 32'(start_cnt - sc0), 1);
    chk("start_mode", 32'(start_mode), 1);
    axi_read(7'h00, rd);
    chk("ctrl_read", rd, 32'h2);
    core_busy = 1'b1;
    sc0 = start_cnt;
    axi_write(7'h00, 32'h3, 4'hF);
    chk("busy_no_start", 32'(start_cnt - sc0), 0);
    axi_read(7'h04, rd);
    chk("status_busy", rd, 32'h1);
    core_busy = 1'b0;

    // Done capture with interrupt enabled.
    @(negedge clk);
    core_dout = 128'hFEDCBA98_76543210_01234567_89ABCDEF; core_done = 1'b1;
    @(negedge clk); core_done = 1'b0; #1;
    chk("irq_after_done", 32'(irq), 1);
    axi_read(7'h40, rd); chk("dout0", rd, 32'h89ABCDEF);
    axi_read(7'h44, rd); chk("dout1", rd, 32'h01234567);
    axi_read(7'h4C, rd); chk("dout3", rd, 32'hFEDCBA98);
    axi_read(7'h04, rd); chk("status_done", rd, 32'h2);
    axi_write(7'h04, 32'h2, 4'b1110);
    axi_read(7'h04, rd); chk("w1c_strb0_low", rd, 32'h2);

    // W1C of DONE in the same cycle as another core_done: set wins.
    @(negedge clk);
    awaddr = 7'h04; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    core_done = 1'b1; core_dout = 128'h1;
    #1; chk("coinc_awready", 32'(awready), 1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; core_done = 0; bready = 1;
    #1; chk("coinc_irq", 32'(irq), 1);
    @(negedge clk); bready = 0;
    axi_read(7'h04, rd); chk("coinc_done", rd, 32'h2);
    axi_read(7'h40, rd); chk("coinc_dout0", rd, 32'h1);
    axi_write(7'h04, 32'h2, 4'hF);
    chk("irq_cleared", 32'(irq), 0);
    axi_read(7'h04, rd); chk("status_cleared", rd, 32'h0);

    // Masked interrupt: DONE still sets, irq stays low.
    axi_write(7'h08, 32'h0, 4'hF);
    @(negedge clk); core_done = 1'b1;
    @(negedge clk); core_done = 1'b0; #1;
    chk("irq_masked", 32'(irq), 0);
    axi_read(7'h04, rd); chk("status_masked", rd, 32'h2);

    // Back-pressure: AW alone waits, then one handshake; responses held 10 cycles.
    @(negedge clk);
    awaddr = 7'h14; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; bready = 0; rready = 0;
    for (int c = 0; c < 3; c++) begin
      #1; chk($sformatf("aw_alone_c%0d", c), 32'(awready), 0);
      @(negedge clk);
    end
    wvalid = 1; #1;
    chk("aw_w_together", 32'({awready, wready}), 32'h3);
    @(negedge clk);
    wdata = 32'h66; araddr = 7'h14; arvalid = 1; #1;
    chk("bp_bvalid", 32'(bvalid), 1);
    chk("bp_no_second_aw", 32'(awready), 0);
    chk("bp_arready", 32'(arready), 1);
    @(negedge clk); arvalid = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("bp_hold_c%0d", c),
          {bvalid, awready, wready, rvalid, rdata[27:0]}, {4'b1001, 28'h55});
      @(negedge clk);
    end
    bready = 1; rready = 1;
    @(negedge clk); #1;
    chk("bp_released", 32'({bvalid, rvalid, awready}), 32'h1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; rready = 0; #1;
    chk("bp_second_bvalid", 32'(bvalid), 1);
    @(negedge clk); bready = 0;
    axi_read(7'h14, rd); chk("bp_key1_final", rd, 32'h66);

    // Reset while a write response is pending drops it and clears the bank.
    @(negedge clk);
    awaddr = 7'h10; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    awvalid = 0; wvalid = 0; #1;
    chk("pre_rst_bvalid", 32'(bvalid), 1);
    srst = 1;
    @(negedge clk); #1;
    chk("mid_rst_bvalid", 32'(bvalid), 0);
    srst = 0;
    axi_read(7'h10, rd); chk("post_rst_key0", rd, 0);
    axi_read(7'h04, rd); chk("post_rst_status", rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_ecb_axil_csr.md
# aes_ecb_axil_csr

Parametrised AXI4-Lite control/status register bank with interrupt logic for the AES ECB engine; successor to the fixed four-register slave. It holds key, input block, mode and start control. It captures the output block, raises a maskable done interrupt, and presents the registers to the PS through one AXI4-Lite slave port. The AES core attaches on the core-side ports.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is legal.
- C_S_AXI_ADDR_WIDTH, 7: byte address width; must cover the full map.
- KEY_WORDS, 4: key length in 32-bit words; legal values are 4, 6 and 8 (AES-128/192/256).
- BLK_WORDS, 4: block length in words; fixed at 4.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY: AXI4-Lite write channels.
- S_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: AXI4-Lite read channels (AWPROT/ARPROT accepted, ignored).
- core_start  out  1  one-cycle start pulse.
- core_mode  out  1  0 = encrypt, 1 = decrypt.
- core_key  out  32*KEY_WORDS  key; word 0 is the least-significant word.
- core_din  out  128  input block.
- core_busy  in  1  core is processing.
- core_done  in  1  one-cycle pulse; core_dout is valid in the same cycle.
- core_dout  in  128  output block.
- irq  out  1  level interrupt, active-high.

## Operation
Register map (byte offsets):
- 0x00 CTRL: bit0 START is write-1-to-pulse and reads 0; bit1 MODE is RW.
- 0x04 STATUS: bit0 BUSY is RO and mirrors core_busy; bit1 DONE is sticky and write-1-to-clear.
- 0x08 IRQ_EN: bit0 is RW.
- 0x0C: reserved; reads 0.
- 0x10 + 4k: KEY[k], RW, for k < KEY_WORDS.
- DIN_BASE = 0x10 + 4*KEY_WORDS: DIN[0..3], RW.
- DOUT_BASE = DIN_BASE + 16: DOUT[0..3], RO.

Register behaviour:
- Addresses are decoded on word index (addr[C_S_AXI_ADDR_WIDTH-1:2]). Unmapped addresses read 0 and ignore writes.
- BRESP and RRESP are always OKAY.
- WSTRB byte enables apply to all RW bytes. START and the DONE clear act only if WSTRB[0] = 1.
- A START write while core_busy = 1 is ignored: no pulse, and the response is still OKAY.
- KEY, DIN and MODE writes are accepted while busy. The core samples them on core_start only.
- On core_done: DOUT is loaded from core_dout and DONE is set.
- If core_done coincides with a DONE W1C, set wins.
- irq = DONE & IRQ_EN[0], driven combinationally from the registers.

Write FSM, states W_IDLE and W_RESP:
- In W_IDLE, when AWVALID and WVALID are both high, assert AWREADY and WREADY for exactly one cycle, perform the write, then go to W_RESP.
- In W_RESP, hold BVALID until BREADY, then return to W_IDLE.
- AW arriving without W (or W without AW) waits; neither channel is accepted alone.

Read FSM, states R_IDLE and R_DATA:
- In R_IDLE, on ARVALID assert ARREADY for one cycle and register RDATA, then go to R_DATA.
- In R_DATA, hold RVALID and RDATA stable until RREADY, then return to R_IDLE.

The read and write paths operate independently and may handshake in the same cycle. A read in the same cycle as a write to the same register returns the old value.

## Timing
- Reset: all READY/VALID outputs are 0 and RDATA = 0. All registers reset to 0: CTRL, DONE, IRQ_EN, KEY, DIN, DOUT. core_start = 0 and irq = 0. Both FSMs go to IDLE. Reset mid-transaction drops the pending B or R response.
- Write: the handshake occurs in cycle T; the register updates and BVALID rises at T+1; core_start is high in T+1 only. Best-case throughput is one write per 2 cycles.
- Read: ARREADY is high in T; RDATA is a snapshot of the registers at T; RVALID is high from T+1.
- core_done in cycle T: DOUT and DONE update at T+1; irq is high at T+1 if enabled.
- A DONE clear at T: irq falls at T+1.

## Structure
- Package aes_csr_pkg holds:
  - offset constants: CTRL, STATUS, IRQ_EN, KEY_BASE;
  - bit-position constants: START, MODE, BUSY, DONE;
  - the RESP_OKAY constant;
  - FSM state typedefs;
  - function din_base(KEY_WORDS).
- Sub-module aes_axil_slv_if holds both handshake FSMs. It exposes a one-cycle wr_en/wr_addr/wr_data/wr_strb strobe and rd_en/rd_addr with an rd_data input. aes_ecb_axil_csr holds the decode and register storage.

## Test plan
- Reset, then read 0x00–0x0C -> all return 0x00000000; irq = 0.
- KEY_WORDS = 8: write 0x11111111..0x88888888 to KEY[0..7] and 0xA0..0xA3 to DIN -> readback matches; core_key[31:0] = 0x11111111; DIN_BASE = 0x30.
- Write WDATA = 0xFFFFFFFF with WSTRB = 4'b0101 to KEY[0] (previously 0) -> readback 0x00FF00FF.
- Write CTRL = 0x3 -> core_start high for exactly one cycle with core_mode = 1. Repeat with core_busy = 1 -> no pulse, BRESP = OKAY.
- IRQ_EN = 1; drive core_done with core_dout = 128'h0123…CDEF -> DOUT[0] reads 0x89ABCDEF; STATUS = 0x2; irq = 1. W1C of DONE in the same cycle as a second core_done -> DONE stays 1.
- Hold BREADY/RREADY low for 10 cycles with AWVALID/WVALID presented 3 cycles apart -> a single handshake, BVALID/RVALID held with stable data, and no second acceptance until the response completes.
